// File: rtl/sram_cache_controller_pkg.sv
// Shared configuration for the 2-way write-through word cache:
// geometry, data-memory base address, FSM state encoding and address helpers.
package sram_cache_controller_pkg;

   localparam int SET_BITS = 6;
   localparam int TAG_BITS = 10;
   localparam int NUM_SETS = 1 << SET_BITS;

   localparam logic [31:0] BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RMISS = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // Byte offset into data memory; index and tag are sliced from this.
   function automatic logic [31:0] mem_offset(input logic [31:0] addr);
      return addr - BASE_ADDR;
   endfunction

endpackage

// File: rtl/sram_cache_controller_way_array.sv
// One way of the cache: valid/tag/data per set.
// Synchronous write, asynchronous read by index, synchronous clear of valid bits.
module cache_way_array
   import sram_cache_controller_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [SET_BITS-1:0] idx_i,
   input  logic                we_i,
   input  logic [TAG_BITS-1:0] tag_i,
   input  logic [31:0]         data_i,
   output logic                valid_o,
   output logic [TAG_BITS-1:0] tag_o,
   output logic [31:0]         data_o
);

   logic [NUM_SETS-1:0] valid_q;
   logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
   logic [31:0]         data_q [NUM_SETS];

   // Valid bits: cleared on reset, set whenever a line is written.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= {NUM_SETS{1'b0}};
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   // Tag and data storage; left unreset because valid guards every use.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[idx_i]  <= tag_i;
         data_q[idx_i] <= data_i;
      end
   end

   assign valid_o = valid_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign data_o  = data_q[idx_i];

endmodule

// File: rtl/sram_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate word cache sitting
// between the MEM stage and the SRAM controller. Read hits complete in the
// same cycle; read misses and all writes freeze the pipeline via ready until
// the SRAM controller reports completion.
// Optional build macro CACHE_STATS_EN adds hit_count / miss_count outputs.
module sram_cache_controller
   import sram_cache_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        sram_read_en,
   output logic        sram_write_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_write_data,
   input  logic [31:0] sram_read_data,
   input  logic        sram_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   state_t              state_q, state_d;
   logic [NUM_SETS-1:0] lru_q, lru_d;

   logic [31:0]         off_s;
   logic [SET_BITS-1:0] idx_s;
   logic [TAG_BITS-1:0] tag_s;
   logic                unused_off_s;

   logic                v0_s, v1_s;
   logic [TAG_BITS-1:0] t0_s, t1_s;
   logic [31:0]         d0_s, d1_s;
   logic                hit0_s, hit1_s, hit_s, hit_way_s, victim_s;

   logic                we0_s, we1_s;
   logic [31:0]         line_data_s;
   logic                lru_we_s, lru_val_s;

   logic                ready_s, sram_read_en_s, sram_write_en_s;
   logic [31:0]         read_data_s;

   assign off_s        = mem_offset(address);
   assign idx_s        = off_s[SET_BITS+1:2];
   assign tag_s        = off_s[SET_BITS+TAG_BITS+1:SET_BITS+2];
   assign unused_off_s = ^{off_s[31:SET_BITS+TAG_BITS+2], off_s[1:0]};

   cache_way_array u_way0 (
      .clk_i   (clk),
      .rst_ni  (rst),
      .idx_i   (idx_s),
      .we_i    (we0_s),
      .tag_i   (tag_s),
      .data_i  (line_data_s),
      .valid_o (v0_s),
      .tag_o   (t0_s),
      .data_o  (d0_s)
   );

   cache_way_array u_way1 (
      .clk_i   (clk),
      .rst_ni  (rst),
      .idx_i   (idx_s),
      .we_i    (we1_s),
      .tag_i   (tag_s),
      .data_i  (line_data_s),
      .valid_o (v1_s),
      .tag_o   (t1_s),
      .data_o  (d1_s)
   );

   assign hit0_s    = v0_s && (t0_s == tag_s);
   assign hit1_s    = v1_s && (t1_s == tag_s);
   assign hit_s     = hit0_s || hit1_s;
   assign hit_way_s = hit1_s;
   // First invalid way (way0 preferred), otherwise the least-recently-used way.
   assign victim_s  = !v0_s ? 1'b0 : (!v1_s ? 1'b1 : lru_q[idx_s]);

   // State register; reset drops any outstanding SRAM request.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: misses and writes wait for the SRAM controller's ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (read_en) begin
               if (hit_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RMISS;
               end
            end else if (write_en) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RMISS: begin
            if (sram_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RMISS;
            end
         end
         S_WRITE: begin
            if (sram_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WRITE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs, line writes and LRU updates; all forced quiet while in reset.
   always_comb begin
      ready_s         = 1'b1;
      sram_read_en_s  = 1'b0;
      sram_write_en_s = 1'b0;
      read_data_s     = 32'h0000_0000;
      we0_s           = 1'b0;
      we1_s           = 1'b0;
      line_data_s     = write_data;
      lru_we_s        = 1'b0;
      lru_val_s       = 1'b0;
      if (!rst) begin
         ready_s = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (read_en) begin
                  if (hit_s) begin
                     read_data_s = hit_way_s ? d1_s : d0_s;
                     lru_we_s    = 1'b1;
                     lru_val_s   = ~hit_way_s;
                  end else begin
                     ready_s        = 1'b0;
                     sram_read_en_s = 1'b1;
                  end
               end else if (write_en) begin
                  ready_s         = 1'b0;
                  sram_write_en_s = 1'b1;
               end else begin
                  ready_s = 1'b1;
               end
            end
            S_RMISS: begin
               if (sram_ready) begin
                  read_data_s = sram_read_data;
                  line_data_s = sram_read_data;
                  we0_s       = ~victim_s;
                  we1_s       = victim_s;
                  lru_we_s    = 1'b1;
                  lru_val_s   = ~victim_s;
               end else begin
                  ready_s = 1'b0;
               end
            end
            S_WRITE: begin
               if (sram_ready) begin
                  line_data_s = write_data;
                  we0_s       = hit0_s;
                  we1_s       = hit1_s;
                  lru_we_s    = hit_s;
                  lru_val_s   = ~hit_way_s;
               end else begin
                  ready_s = 1'b0;
               end
            end
            default: ready_s = 1'b1;
         endcase
      end
   end

   // LRU next-state: rewrite only the addressed set's bit.
   always_comb begin
      lru_d = lru_q;
      if (lru_we_s) begin
         lru_d[idx_s] = lru_val_s;
      end else begin
         lru_d = lru_q;
      end
   end

   // LRU register: every set starts pointing at way0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lru_q <= {NUM_SETS{1'b0}};
      end else begin
         lru_q <= lru_d;
      end
   end

   assign ready           = ready_s;
   assign read_data       = read_data_s;
   assign sram_read_en    = sram_read_en_s;
   assign sram_write_en   = sram_write_en_s;
   assign sram_address    = address;
   assign sram_write_data = write_data;

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_q, miss_count_q;

   // Hit/miss statistics for loads accepted in S_IDLE; both wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else if ((state_q == S_IDLE) && read_en) begin
         if (hit_s) begin
            hit_count_q <= hit_count_q + 32'd1;
         end else begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_sram_cache_controller.sv
// Self-checking bench for sram_cache_controller: directed table, randomized
// traffic against a set/way reference model, and reset in the middle of a miss.
module tb_sram_cache_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        read_en = 1'b0;
   logic        write_en = 1'b0;
   logic [31:0] address = 32'd1024;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        ready;
   logic        sram_read_en;
   logic        sram_write_en;
   logic [31:0] sram_address;
   logic [31:0] sram_write_data;
   logic [31:0] sram_read_data = 32'd0;
   logic        sram_ready = 1'b1;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int cmp_cnt = 0;
   int err_cnt = 0;
   int next_wait = 2;
   int busy_cnt = 0;

   bit          sram_wr_v [4096];
   logic [31:0] sram_wr_d [4096];

   // reference model state
   bit          ref_v   [64][2];
   logic [9:0]  ref_t   [64][2];
   logic [31:0] ref_d   [64][2];
   int          ref_lru [64];
   bit          ref_mv  [4096];
   logic [31:0] ref_md  [4096];
   int          ref_hits = 0;
   int          ref_misses = 0;

   sram_cache_controller dut (
      .clk             (clk),
      .rst             (rst),
      .read_en         (read_en),
      .write_en        (write_en),
      .address         (address),
      .write_data      (write_data),
      .read_data       (read_data),
      .ready           (ready),
      .sram_read_en    (sram_read_en),
      .sram_write_en   (sram_write_en),
      .sram_address    (sram_address),
      .sram_write_data (sram_write_data),
      .sram_read_data  (sram_read_data),
      .sram_ready      (sram_ready)
`ifdef CACHE_STATS_EN
      ,
      .hit_count       (hit_count),
      .miss_count      (miss_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a == 32'd1024) return 32'hDEAD_BEEF;
      if (a == 32'd1280) return 32'h1111_1111;
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] w;
      w = (a - 32'd1024) >> 2;
      return int'(w[11:0]);
   endfunction

   // Behavioural SRAM controller: ready drops for next_wait cycles after a request.
   always @(posedge clk) begin
      if (!rst) begin
         sram_ready <= 1'b1;
         busy_cnt   <= 0;
      end else if (sram_read_en || sram_write_en) begin
         sram_ready <= 1'b0;
         busy_cnt   <= next_wait;
         if (sram_write_en) begin
            sram_wr_v[widx(sram_address)] <= 1'b1;
            sram_wr_d[widx(sram_address)] <= sram_write_data;
         end
         sram_read_data <= sram_wr_v[widx(sram_address)] ? sram_wr_d[widx(sram_address)]
                                                          : init_val(sram_address);
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) sram_ready <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic int set_of(input logic [31:0] a);
      return int'(((a - 32'd1024) / 4) % 64);
   endfunction

   function automatic logic [9:0] tag_of(input logic [31:0] a);
      logic [31:0] t;
      t = ((a - 32'd1024) / 256) % 1024;
      return t[9:0];
   endfunction

   function automatic logic [31:0] ref_mem(input logic [31:0] a);
      return ref_mv[widx(a)] ? ref_md[widx(a)] : init_val(a);
   endfunction

   task automatic model_find(input logic [31:0] a, output bit hit, output int way);
      int s;
      s = set_of(a);
      hit = 1'b0;
      way = 0;
      for (int w = 0; w < 2; w++) begin
         if (ref_v[s][w] && ref_t[s][w] == tag_of(a)) begin
            hit = 1'b1;
            way = w;
         end
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         ref_v[s][0] = 1'b0;
         ref_v[s][1] = 1'b0;
         ref_lru[s]  = 0;
      end
      ref_hits = 0;
      ref_misses = 0;
   endtask

   task automatic model_commit(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
      bit hit;
      int way, s, vic;
      model_find(a, hit, way);
      s = set_of(a);
      if (rd) begin
         if (hit) begin
            ref_lru[s] = 1 - way;
            ref_hits++;
         end else begin
            if (!ref_v[s][0]) vic = 0;
            else if (!ref_v[s][1]) vic = 1;
            else vic = ref_lru[s];
            ref_v[s][vic] = 1'b1;
            ref_t[s][vic] = tag_of(a);
            ref_d[s][vic] = ref_mem(a);
            ref_lru[s] = 1 - vic;
            ref_misses++;
         end
      end else if (wr) begin
         ref_mv[widx(a)] = 1'b1;
         ref_md[widx(a)] = wd;
         if (hit) begin
            ref_d[s][way] = wd;
            ref_lru[s] = 1 - way;
         end
      end
   endtask

   // Apply one request (starting just after a rising edge) and check it end to end.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input bit exp_hit, input logic [31:0] exp_data, input string nm);
      bit stall, done;
      int cycles;
      stall = (rd && !exp_hit) || (!rd && wr);
      next_wait = $urandom_range(1, 4);
      read_en = rd;
      write_en = wr;
      address = a;
      write_data = wd;
      @(negedge clk);
      chk({nm, " ready"}, {31'd0, ready}, {31'd0, !stall});
      chk({nm, " sram_read_en"}, {31'd0, sram_read_en}, {31'd0, rd && !exp_hit});
      chk({nm, " sram_write_en"}, {31'd0, sram_write_en}, {31'd0, !rd && wr});
      if (wr) chk({nm, " sram_wdata"}, sram_write_data, wd);
      if (rd || wr) chk({nm, " sram_address"}, sram_address, a);
      if (rd && !stall) chk({nm, " hit data"}, read_data, exp_data);
      if (stall) begin
         cycles = 1;
         done = 1'b0;
         for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            chk({nm, " no repeat req"}, {30'd0, sram_read_en, sram_write_en}, 32'd0);
            if (ready) done = 1'b1;
         end
         chk({nm, " completed"}, {31'd0, done}, 32'd1);
         chk({nm, " stall cycles"}, cycles, next_wait + 2);
         if (rd) chk({nm, " miss data"}, read_data, exp_data);
      end
      @(posedge clk);
      #1;
      read_en = 1'b0;
      write_en = 1'b0;
      model_commit(rd, wr, a, wd);
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          hit;
      logic [31:0] data;
      string       nm;
   } vec_t;

   vec_t tbl[14];

   initial begin
      bit hit;
      int way, op;
      logic [31:0] a, wd, ed;

      tbl[0]  = '{1'b0, 1'b0, 32'd1024, 32'd0,         1'b0, 32'd0,         "idle"};
      tbl[1]  = '{1'b1, 1'b0, 32'd1024, 32'd0,         1'b0, 32'hDEADBEEF, "rd1024 miss"};
      tbl[2]  = '{1'b1, 1'b0, 32'd1024, 32'd0,         1'b1, 32'hDEADBEEF, "rd1024 hit"};
      tbl[3]  = '{1'b1, 1'b0, 32'd1280, 32'd0,         1'b0, 32'h11111111, "rd1280 miss"};
      tbl[4]  = '{1'b1, 1'b0, 32'd1536, 32'd0,         1'b0, 32'hA5A50600, "rd1536 evict"};
      tbl[5]  = '{1'b1, 1'b0, 32'd1280, 32'd0,         1'b1, 32'h11111111, "rd1280 hit"};
      tbl[6]  = '{1'b1, 1'b0, 32'd1024, 32'd0,         1'b0, 32'hDEADBEEF, "rd1024 remiss"};
      tbl[7]  = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b1, 32'd0,         "wr1024"};
      tbl[8]  = '{1'b1, 1'b0, 32'd1024, 32'd0,         1'b1, 32'h12345678, "rd1024 updated"};
      tbl[9]  = '{1'b1, 1'b1, 32'd1024, 32'hCAFE0000, 1'b1, 32'h12345678, "rd+wr priority"};
      tbl[10] = '{1'b0, 1'b1, 32'd2048, 32'hCAFEF00D, 1'b0, 32'd0,         "wr2048 noalloc"};
      tbl[11] = '{1'b1, 1'b0, 32'd2048, 32'd0,         1'b0, 32'hCAFEF00D, "rd2048 miss"};
      tbl[12] = '{1'b1, 1'b0, 32'd1280, 32'd0,         1'b0, 32'h11111111, "rd1280 evicted"};
      tbl[13] = '{1'b1, 1'b0, 32'd2048, 32'd0,         1'b1, 32'hCAFEF00D, "rd2048 hit"};

      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ready", {31'd0, ready}, 32'd1);
      chk("reset sram_read_en", {31'd0, sram_read_en}, 32'd0);
      chk("reset sram_write_en", {31'd0, sram_write_en}, 32'd0);
      chk("reset read_data", read_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
`ifdef CACHE_STATS_EN
      @(negedge clk);
      chk("reset hit_count", hit_count, 32'd0);
      chk("reset miss_count", miss_count, 32'd0);
      @(posedge clk);
      #1;
`endif

      // directed table
      for (int i = 0; i < 14; i++) begin
         do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].hit, tbl[i].data, tbl[i].nm);
      end

      // randomized traffic against the reference model
      for (int i = 0; i < 200; i++) begin
         a  = 32'd1024 + (32'($urandom_range(0, 7)) << 8) + (32'($urandom_range(0, 3)) << 2);
         wd = $urandom;
         op = $urandom_range(0, 3);
         model_find(a, hit, way);
         ed = hit ? ref_d[set_of(a)][way] : ref_mem(a);
         do_access(op == 1 || op == 3, op == 2 || op == 3, a, wd, hit, ed, "random");
      end

`ifdef CACHE_STATS_EN
      @(negedge clk);
      chk("hit_count", hit_count, 32'(ref_hits));
      chk("miss_count", miss_count, 32'(ref_misses));
      @(posedge clk);
      #1;
`endif

      // reset in the middle of a read miss
      next_wait = 4;
      read_en = 1'b1;
      address = 32'h0000_3400;
      @(negedge clk);
      chk("rstmiss issue ready", {31'd0, ready}, 32'd0);
      chk("rstmiss issue req", {31'd0, sram_read_en}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("rstmiss stalled", {31'd0, ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rstmiss in reset ready", {31'd0, ready}, 32'd1);
      chk("rstmiss in reset req", {31'd0, sram_read_en}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      read_en = 1'b0;
      model_reset();
      @(negedge clk);
      chk("after reset ready", {31'd0, ready}, 32'd1);
      chk("after reset no req", {30'd0, sram_read_en, sram_write_en}, 32'd0);
`ifdef CACHE_STATS_EN
      chk("after reset hit_count", hit_count, 32'd0);
      chk("after reset miss_count", miss_count, 32'd0);
`endif
      @(posedge clk);
      #1;
      do_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, ref_mem(32'd1024), "rd1024 after reset");
      do_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, ref_mem(32'd1024), "rd1024 rehit");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_cache_controller.md
Name: sram_cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate word cache between the MEM stage and the SRAM controller.
- Read hits return data the same cycle with no stall.
- Read misses and all writes are forwarded to the SRAM controller; the pipeline is frozen through `ready` until the SRAM controller reports completion.

Parameters:
- SET_BITS, 6: index width; 64 sets.
- TAG_BITS, 10: tag width; covers physical word address bits [17:8].
- BASE_ADDR, 1024: data-memory base byte address, subtracted before indexing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- read_en  in  1  MEM-stage load request.
- write_en  in  1  MEM-stage store request.
- address  in  32  byte address, word aligned, >= BASE_ADDR.
- write_data  in  32  store data.
- read_data  out  32  load data, valid when read_en && ready.
- ready  out  1  0 = freeze pipeline.
- sram_read_en  out  1  one-cycle read request to SRAM controller.
- sram_write_en  out  1  one-cycle write request to SRAM controller.
- sram_address  out  32  equals address (unmodified byte address).
- sram_write_data  out  32  equals write_data.
- sram_read_data  in  32  SRAM controller read data.
- sram_ready  in  1  SRAM controller ready; 0 while its access is in progress.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-low: sampled on the rising edge when 0.
- Reset values: state=S_IDLE; all valid bits cleared; all LRU bits 0; ready=1; sram_read_en=0; sram_write_en=0; read_data=0.
- Address split: off = address - BASE_ADDR; index = off[SET_BITS+1:2]; tag = off[SET_BITS+TAG_BITS+1:SET_BITS+2].
- Per set: two ways, each holding valid, tag and 32-bit data, plus 1 LRU bit naming the least-recently-used way.
- Hit: valid && tag match. A hit on both ways cannot occur.
- Request priority: read_en has priority if both are asserted. The pipeline holds all inputs stable while ready=0.
- S_IDLE:
  - read hit: read_data = hit-way data (combinational); ready=1; LRU = ~hit_way at the edge; stay in S_IDLE.
  - read miss: ready=0; sram_read_en=1 (combinational, this cycle only); next state S_RMISS.
  - write: ready=0; sram_write_en=1 (this cycle only); next state S_WRITE.
  - no request: ready=1.
- S_RMISS:
  - sram_read_en=0.
  - While sram_ready=0: ready=0.
  - First cycle with sram_ready=1: read_data = sram_read_data; ready=1.
  - At that edge: fill the victim way (valid=1, tag, data); LRU = ~victim; next state S_IDLE.
- S_WRITE:
  - sram_write_en=0; ready=0 until sram_ready=1.
  - In the completion cycle: ready=1.
  - At that edge: if the address hits, update that way's data and set LRU = ~hit_way. A miss allocates nothing. Next state S_IDLE.
- Victim selection: first invalid way, way0 before way1. If both ways are valid, the LRU way.
- sram_ready=1 in the S_IDLE issue cycle is ignored.
- Completion latency: one cycle after the SRAM controller returns ready. Miss stall = SRAM access length (`SRAM_WAIT_CYCLES` + 2 cycles).
- A read of an address that is mid-write cannot occur: the pipeline is frozen.
- Reset mid-miss or mid-write: return to S_IDLE, invalidate all lines, drop the outstanding request. The SRAM controller is reset by the same rst.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Reset to 0.
  - hit_count increments on each S_IDLE read hit.
  - miss_count increments on each S_IDLE → S_RMISS transition.
  - Both wrap at 2^32; writes are not counted.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/configs: state encodings S_IDLE/S_RMISS/S_WRITE, BASE_ADDR, SET_BITS, TAG_BITS.
- Sub-module cache_way_array: tag/valid/data storage for one way.
  - Synchronous write; asynchronous read by index; synchronous clear of valid bits.
  - Instantiated twice.
- LRU bits and the FSM stay in the top module.

Test Plan:
- Reset, then read 1024 → miss: sram_read_en pulses 1 cycle; ready=0 until sram_ready=1. SRAM data 0xDEADBEEF returned on read_data; set 0 way0 valid.
- Read 1024 again → hit: ready=1 same cycle; read_data=0xDEADBEEF; no sram_read_en.
- Read 1024, 1024+256, 1024+512 (all set 0) → third miss evicts way0 (LRU). A re-read of 1024 misses; a re-read of 1280 hits.
- Write 0x12345678 to 1024 after it is cached → sram_write_en pulses; stall until sram_ready. A subsequent read hits with 0x12345678.
- Write to uncached 2048 → SRAM write issued, no allocation. A following read of 2048 misses.
- Assert rst=0 during S_RMISS → next cycle state idle; ready=1; read of 1024 misses. With CACHE_STATS_EN, counters read 0.
